// File: rtl/trap_csr_unit.sv
// Trap/CSR unit: interrupt pending capture, trap entry/return sequencing and the CSR file
// that configures it (STATUS, INTMASK, SCAUSE, EPC, TVEC, CAUSE).
//
// state   | meaning
// IDLE    | normal execution, waiting for the exception unit to request a trap
// ENTER   | one cycle: redirect/flush to the trap vector
// HANDLER | running the trap handler, waiting for eret
// RETURN  | one cycle: redirect/flush back to EPC
module trap_csr_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  irq_in,
    input  logic [31:0] pc_in,
    input  logic        stall,
    input  logic        int_signal,
    input  logic        exl_set,
    input  logic [2:0]  int_pend,
    input  logic        eret,
    input  logic        csr_we,
    input  logic [2:0]  csr_addr,
    input  logic [31:0] csr_wdata,
    output logic [31:0] csr_rdata,
    output logic [7:0]  status,
    output logic [7:0]  scause,
    output logic [7:0]  intmask,
    output logic        redirect,
    output logic        flush,
    output logic [31:0] redirect_pc
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ENTER   = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic        w_take_trap;

    logic [7:0]  r_status;
    logic [7:0]  r_intmask;
    logic [7:0]  r_scause;
    logic [7:0]  r_irq_sync;
    logic [31:0] r_epc;
    logic [31:0] r_tvec;
    logic [2:0]  r_cause;

    logic        w_wr_status;
    logic        w_wr_intmask;
    logic        w_wr_scause;
    logic        w_wr_epc;
    logic        w_wr_tvec;
    logic [7:0]  w_irq_edge;
    logic [7:0]  w_scause_clr;

    assign w_wr_status  = csr_we && (csr_addr == 3'd0);
    assign w_wr_intmask = csr_we && (csr_addr == 3'd1);
    assign w_wr_scause  = csr_we && (csr_addr == 3'd2);
    assign w_wr_epc     = csr_we && (csr_addr == 3'd3);
    assign w_wr_tvec    = csr_we && (csr_addr == 3'd4);

    // Sync register resets to 0, so a line held high through reset shows up as an edge.
    assign w_irq_edge   = irq_in & ~r_irq_sync;
    assign w_scause_clr = (w_wr_scause ? csr_wdata[7:0] : 8'h00)
                        | ((r_state == ST_ENTER) ? (8'h01 << r_cause) : 8'h00);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_take_trap = 1'b0;
        redirect    = 1'b0;
        flush       = 1'b0;
        redirect_pc = 32'h0;
        case (r_state)
            ST_IDLE: begin
                if (int_signal && exl_set && !stall) begin
                    w_take_trap = 1'b1;
                    w_state_nxt = ST_ENTER;
                end
            end
            ST_ENTER: begin
                redirect    = 1'b1;
                flush       = 1'b1;
                redirect_pc = r_tvec + {27'd0, r_cause, 2'b00};
                w_state_nxt = ST_HANDLER;
            end
            ST_HANDLER: begin
                if (eret) begin
                    w_state_nxt = ST_RETURN;
                end
            end
            ST_RETURN: begin
                redirect    = 1'b1;
                flush       = 1'b1;
                redirect_pc = r_epc;
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_status   <= 8'h00;
            r_intmask  <= 8'h00;
            r_scause   <= 8'h00;
            r_irq_sync <= 8'h00;
            r_epc      <= 32'h0;
            r_tvec     <= 32'h0000_0100;
            r_cause    <= 3'd0;
        end else begin
            r_irq_sync <= irq_in;
            r_scause   <= (r_scause & ~w_scause_clr) | w_irq_edge;

            // Hardware EXL update is assigned last so it overrides a software write of bit1.
            if (w_wr_status) begin
                r_status <= csr_wdata[7:0];
            end
            if (r_state == ST_ENTER) begin
                r_status[1] <= 1'b1;
            end else if (r_state == ST_RETURN) begin
                r_status[1] <= 1'b0;
            end

            if (w_wr_intmask) begin
                r_intmask <= csr_wdata[7:0];
            end
            if (w_wr_tvec) begin
                r_tvec <= {csr_wdata[31:2], 2'b00};
            end

            if (w_take_trap) begin
                r_epc   <= pc_in;
                r_cause <= int_pend;
            end else if (w_wr_epc) begin
                r_epc <= csr_wdata;
            end
        end
    end

    always_comb begin
        csr_rdata = 32'h0;
        case (csr_addr)
            3'd0:    csr_rdata = {24'h0, r_status};
            3'd1:    csr_rdata = {24'h0, r_intmask};
            3'd2:    csr_rdata = {24'h0, r_scause};
            3'd3:    csr_rdata = r_epc;
            3'd4:    csr_rdata = r_tvec;
            3'd5:    csr_rdata = {29'h0, r_cause};
            default: csr_rdata = 32'h0;
        endcase
    end

    // EXL is forced visible during ENTER so the exception unit cannot re-fire.
    assign status  = {r_status[7:2], r_status[1] | (r_state == ST_ENTER), r_status[0]};
    assign scause  = r_scause;
    assign intmask = r_intmask;

endmodule

// File: tb/tb_trap_csr_unit.sv
// Directed bench for trap_csr_unit with a simple exception-unit model looped back
// from status/scause/intmask onto int_signal/exl_set/int_pend.
module tb_trap_csr_unit;

    logic        clk;
    logic        rst;
    logic [7:0]  irq_in;
    logic [31:0] pc_in;
    logic        stall;
    logic        int_signal;
    logic        exl_set;
    logic [2:0]  int_pend;
    logic        eret;
    logic        csr_we;
    logic [2:0]  csr_addr;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic [7:0]  status;
    logic [7:0]  scause;
    logic [7:0]  intmask;
    logic        redirect;
    logic        flush;
    logic [31:0] redirect_pc;

    int total = 0;
    int bad   = 0;

    trap_csr_unit dut (
        .clk         (clk),
        .rst         (rst),
        .irq_in      (irq_in),
        .pc_in       (pc_in),
        .stall       (stall),
        .int_signal  (int_signal),
        .exl_set     (exl_set),
        .int_pend    (int_pend),
        .eret        (eret),
        .csr_we      (csr_we),
        .csr_addr    (csr_addr),
        .csr_wdata   (csr_wdata),
        .csr_rdata   (csr_rdata),
        .status      (status),
        .scause      (scause),
        .intmask     (intmask),
        .redirect    (redirect),
        .flush       (flush),
        .redirect_pc (redirect_pc)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Exception unit: request when an enabled interrupt is pending, IE=1 and EXL=0.
    logic [7:0] lb_active;
    logic [2:0] lb_pend;
    assign lb_active  = scause & intmask;
    assign int_signal = (lb_active != 8'h00) && status[0] && !status[1];
    assign exl_set    = int_signal;
    assign int_pend   = lb_pend;
    always_comb begin
        lb_pend = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (lb_active[i]) lb_pend = i[2:0];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [2:0] addr, input logic [31:0] exp);
        csr_addr = addr;
        #1;
        chk(tag, csr_rdata, exp);
    endtask

    initial begin
        rst = 1'b1; irq_in = 8'h00; pc_in = 32'h0; stall = 1'b0; eret = 1'b0;
        csr_we = 1'b0; csr_addr = 3'd0; csr_wdata = 32'h0;
        tick(); tick();
        chk("rst_redirect", {31'h0, redirect}, 32'h0);
        chk("rst_flush", {31'h0, flush}, 32'h0);
        rd("rst_status", 3'd0, 32'h0);
        rd("rst_intmask", 3'd1, 32'h0);
        rd("rst_scause", 3'd2, 32'h0);
        rd("rst_epc", 3'd3, 32'h0);
        rd("rst_tvec", 3'd4, 32'h100);
        rd("rst_cause", 3'd5, 32'h0);
        rst = 1'b0;
        tick();

        // Basic trap entry
        csr_we = 1'b1; csr_addr = 3'd1; csr_wdata = 32'h04; tick();
        csr_addr = 3'd0; csr_wdata = 32'h01; tick();
        csr_we = 1'b0;
        chk("a_intmask", {24'h0, intmask}, 32'h04);
        chk("a_status", {24'h0, status}, 32'h01);
        pc_in = 32'h40; irq_in = 8'h04; tick(); irq_in = 8'h00;
        chk("a_scause_set", {24'h0, scause}, 32'h04);
        chk("a_idle_noredir", {31'h0, redirect}, 32'h0);
        tick();
        chk("a_enter_redir", {31'h0, redirect}, 32'h1);
        chk("a_enter_flush", {31'h0, flush}, 32'h1);
        chk("a_enter_pc", redirect_pc, 32'h108);
        chk("a_enter_exl", {24'h0, status}, 32'h03);
        tick();
        chk("a_hnd_redir", {31'h0, redirect}, 32'h0);
        chk("a_hnd_pc", redirect_pc, 32'h0);
        rd("a_epc", 3'd3, 32'h40);
        rd("a_cause", 3'd5, 32'h2);
        rd("a_status_rd", 3'd0, 32'h03);
        rd("a_scause_clr", 3'd2, 32'h00);

        // Return
        eret = 1'b1; tick(); eret = 1'b0;
        chk("b_ret_redir", {31'h0, redirect}, 32'h1);
        chk("b_ret_flush", {31'h0, flush}, 32'h1);
        chk("b_ret_pc", redirect_pc, 32'h40);
        tick();
        chk("b_idle_redir", {31'h0, redirect}, 32'h0);
        rd("b_status", 3'd0, 32'h01);

        // eret in IDLE is ignored
        eret = 1'b1; tick(); eret = 1'b0;
        chk("c_eret_idle_redir", {31'h0, redirect}, 32'h0);
        rd("c_eret_idle_status", 3'd0, 32'h01);
        tick();
        chk("c_eret_idle_redir2", {31'h0, redirect}, 32'h0);

        // Stall defers entry; EPC write loses to the hardware latch; STATUS write in ENTER
        stall = 1'b1; irq_in = 8'h04; tick(); irq_in = 8'h00;
        for (int i = 0; i < 3; i++) begin
            pc_in = 32'h80 + 32'(4 * i);
            tick();
            chk("d_stall_redir", {31'h0, redirect}, 32'h0);
            rd("d_stall_epc", 3'd3, 32'h40);
        end
        stall = 1'b0; pc_in = 32'hC0;
        csr_we = 1'b1; csr_addr = 3'd3; csr_wdata = 32'hDEAD_BEE0;
        tick();
        chk("d_enter_redir", {31'h0, redirect}, 32'h1);
        chk("d_enter_pc", redirect_pc, 32'h108);
        csr_addr = 3'd0; csr_wdata = 32'h05;
        tick();
        csr_we = 1'b0;
        rd("d_epc_hw_wins", 3'd3, 32'hC0);
        rd("d_status_merge", 3'd0, 32'h07);
        rd("d_scause_clr", 3'd2, 32'h00);

        // Second irq during HANDLER waits until after RETURN
        irq_in = 8'h04; tick(); irq_in = 8'h00;
        chk("e_hnd_scause", {24'h0, scause}, 32'h04);
        chk("e_hnd_redir", {31'h0, redirect}, 32'h0);
        tick();
        chk("e_hnd_redir2", {31'h0, redirect}, 32'h0);
        pc_in = 32'h200; eret = 1'b1; tick(); eret = 1'b0;
        chk("e_ret_redir", {31'h0, redirect}, 32'h1);
        chk("e_ret_pc", redirect_pc, 32'hC0);
        chk("e_ret_status", {24'h0, status}, 32'h07);
        tick();
        chk("e_idle_redir", {31'h0, redirect}, 32'h0);
        chk("e_idle_status", {24'h0, status}, 32'h05);
        tick();
        chk("e_enter2_redir", {31'h0, redirect}, 32'h1);
        chk("e_enter2_pc", redirect_pc, 32'h108);
        tick();
        rd("e_epc2", 3'd3, 32'h200);
        rd("e_scause2", 3'd2, 32'h00);
        eret = 1'b1; tick(); eret = 1'b0;
        tick();
        chk("e_back_idle", {31'h0, redirect}, 32'h0);

        // Edge-set beats W1C on the same bit; W1C alone clears
        irq_in = 8'h20; csr_we = 1'b1; csr_addr = 3'd2; csr_wdata = 32'h20;
        tick();
        chk("f_set_wins", {24'h0, scause}, 32'h20);
        tick();
        csr_we = 1'b0;
        chk("f_w1c", {24'h0, scause}, 32'h00);
        irq_in = 8'h00;

        // Reset during ENTER aborts
        irq_in = 8'h04; tick(); irq_in = 8'h00;
        tick();
        chk("g_enter_redir", {31'h0, redirect}, 32'h1);
        rst = 1'b1; tick(); rst = 1'b0;
        chk("g_rst_redir", {31'h0, redirect}, 32'h0);
        chk("g_rst_flush", {31'h0, flush}, 32'h0);
        chk("g_rst_pc", redirect_pc, 32'h0);
        chk("g_rst_status", {24'h0, status}, 32'h0);
        chk("g_rst_intmask", {24'h0, intmask}, 32'h0);
        chk("g_rst_scause", {24'h0, scause}, 32'h0);
        rd("g_rst_epc", 3'd3, 32'h0);
        rd("g_rst_cause", 3'd5, 32'h0);
        rd("g_rst_tvec", 3'd4, 32'h100);
        tick();
        chk("g_after_rst_redir", {31'h0, redirect}, 32'h0);

        // irq held high through reset produces a pending bit after release
        irq_in = 8'h08; rst = 1'b1; tick(); tick(); rst = 1'b0;
        chk("h_rst_scause", {24'h0, scause}, 32'h00);
        tick();
        chk("h_held_irq_edge", {24'h0, scause}, 32'h08);
        irq_in = 8'h00;

        // TVEC alignment, unmapped and read-only addresses
        csr_we = 1'b1; csr_addr = 3'd4; csr_wdata = 32'h203; tick();
        csr_addr = 3'd6; csr_wdata = 32'hFFFF_FFFF; tick();
        csr_addr = 3'd5; csr_wdata = 32'h7; tick();
        csr_we = 1'b0;
        rd("i_tvec_align", 3'd4, 32'h200);
        rd("i_addr6", 3'd6, 32'h0);
        rd("i_cause_ro", 3'd5, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
